traffic_conflict_monitor: RTL
=============================

Name: traffic_conflict_monitor

Overview:
Safety stage directly downstream of traffic_light_4way. It consumes the controller's four lamp buses and eight turn arrows and passes them to the lamp drivers through a register. It checks every cycle for illegal or conflicting aspects and for bad timing. On a confirmed violation it latches a fault and forces all four heads into flashing red until an operator clear.

Parameters:
DEBOUNCE, 2, consecutive cycles a static violation (codes 1, 2, 5) must persist before the fault latches (min 1)
MIN_YELLOW, 3, minimum consecutive yellow cycles before a yellow->red transition
FLASH_HALF, 4, cycles per half-period of fault flashing
STARTUP_CYCLES, 8, forced all-red cycles after reset or fault clear
Encodings: red=3'b100, yellow=3'b010, green=3'b001.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
north_light / south_light / east_light / west_light  input  3 each  controller lamp buses
{n,s,e,w}_left_arrow, {n,s,e,w}_right_arrow  input  1 each  controller arrows (8 ports, names as on traffic_light_4way)
fault_clear  input  1  operator clear, sampled only in FAULT
safe_north_light / safe_south_light / safe_east_light / safe_west_light  output  3 each  registered lamp drive
safe_{dir}_left_arrow, safe_{dir}_right_arrow  output  1 each  registered arrow drive (8 ports)
fault  output  1  high while in FAULT
fault_code  output  3  code of the latched fault; 0 = none
fault_count  output  8  saturating count of FAULT entries since reset; fault_clear does not reset it

Behaviour:
- Reset is synchronous. While reset is high at an edge: state=STARTUP, startup counter=0, all safe lights=100, all safe arrows=0, fault=0, fault_code=0, fault_count=0, debounce and yellow counters=0.
- STARTUP: outputs are all red with arrows 0. Checks are disabled. After STARTUP_CYCLES edges in this state, the next state is MONITOR.
- MONITOR: outputs take the inputs with 1-cycle latency, but only if the instantaneous check is clean. If any static violation is present, that cycle's outputs are all red with arrows 0, whatever the debounce state, so no conflicting aspect ever reaches an output.
- Static checks, evaluated on the current inputs:
  - Code 1, axis conflict: (N or S != red) and (E or W != red).
  - Code 2, invalid lamp: a light bus is not one-hot (000, 011, 111, ...).
  - Code 5, arrow on red: an arrow is asserted while its own direction light is red.
- Debounce counter:
  - Increments each cycle any static violation is present. Clears on a clean cycle.
  - Reaching DEBOUNCE latches the fault at that same edge.
  - With DEBOUNCE=1, a violation sampled at edge k gives fault=1 after edge k.
- Temporal checks per direction use the previous sample and a saturating yellow counter. The yellow counter counts consecutive yellow cycles and clears otherwise.
  - Code 3: green->red with no yellow in between.
  - Code 4: yellow->red with yellow counter < MIN_YELLOW.
  - Both latch immediately at the edge the red is sampled; there is no debounce.
  - Both are skipped on the first MONITOR cycle.
- Priority: when several faults qualify at the same edge, the lowest code is latched.
- FAULT:
  - fault=1; fault_code holds its value; fault_count increments once on entry and saturates at 255.
  - All safe lights alternate 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, starting with 100 on the entry edge. Arrows are 0.
  - Inputs are ignored.
  - fault_clear=1 at an edge moves to STARTUP and sets fault=0 and fault_code=0. The yellow and debounce counters are cleared.
- Reset mid-operation, in any state, behaves exactly as power-on reset.
- History registers update in every state. Counters never wrap.

Test Plan:
1. Release reset with N=S=001, E=W=100 → 8 cycles of all safe lights 100; then safe_north=001 one cycle after the input; fault stays 0.
2. N=001, E=001 for 1 cycle, then legal → outputs all-red that cycle, no fault. Same conflict held 2 cycles → fault=1, fault_code=1, lights 100×4 then 000×4 repeating, fault_count=1.
3. North 001 followed immediately by 100 → fault_code=3 at that edge. North yellow 2 cycles then red → code 4. Yellow 3 cycles then red → no fault.
4. north_light=000 together with an axis conflict, held 2 cycles → fault_code=1 (priority). Then fault_clear for 1 cycle → fault=0, 8 all-red cycles, passthrough resumes, fault_count stays 1.
5. north_left_arrow=1 with north_light=100 for 2 cycles → fault_code=5.
6. Reset asserted mid-FAULT → STARTUP, all red, fault=0, fault_count=0.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Safety register stage between the 4-way signal controller and the lamp drivers.
// Blanks conflicting aspects, detects bad timing, latches faults and flashes red.
module traffic_conflict_monitor #(
  parameter int DEBOUNCE       = 2,
  parameter int MIN_YELLOW     = 3,
  parameter int FLASH_HALF     = 4,
  parameter int STARTUP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] north_light,
  input  logic [2:0] south_light,
  input  logic [2:0] east_light,
  input  logic [2:0] west_light,
  input  logic       n_left_arrow,
  input  logic       s_left_arrow,
  input  logic       e_left_arrow,
  input  logic       w_left_arrow,
  input  logic       n_right_arrow,
  input  logic       s_right_arrow,
  input  logic       e_right_arrow,
  input  logic       w_right_arrow,
  input  logic       fault_clear,
  output logic [2:0] safe_north_light,
  output logic [2:0] safe_south_light,
  output logic [2:0] safe_east_light,
  output logic [2:0] safe_west_light,
  output logic       safe_n_left_arrow,
  output logic       safe_s_left_arrow,
  output logic       safe_e_left_arrow,
  output logic       safe_w_left_arrow,
  output logic       safe_n_right_arrow,
  output logic       safe_s_right_arrow,
  output logic       safe_e_right_arrow,
  output logic       safe_w_right_arrow,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count
);
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int SW = $clog2(STARTUP_CYCLES + 1);
  localparam int FW = $clog2(2 * FLASH_HALF);

  typedef enum logic [1:0] {ST_STARTUP, ST_MONITOR, ST_FAULT} state_t;

  state_t               state_q, state_d;
  logic [3:0][2:0]      lt_in, lt_q, lt_d, prev_q, prev_d;
  logic [3:0]           la_in, ra_in, la_q, la_d, ra_q, ra_d;
  logic [3:0][YW-1:0]   ycnt_q, ycnt_d;
  logic [SW-1:0]        stc_q, stc_d;
  logic [DW-1:0]        deb_q, deb_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [2:0]           code_q, code_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 mon_q;
  logic                 c1, c2, c5, viol, hit, temp_en;
  logic [3:0]           bad, t3, t4;
  logic [2:0]           new_code;

  // Index 0 = north, 1 = south, 2 = east, 3 = west
  assign lt_in = {west_light, east_light, south_light, north_light};
  assign la_in = {w_left_arrow, e_left_arrow, s_left_arrow, n_left_arrow};
  assign ra_in = {w_right_arrow, e_right_arrow, s_right_arrow, n_right_arrow};

  always_comb begin
    bad = '0;
    t3  = '0;
    t4  = '0;
    c5  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bad[i] = !(lt_in[i] == RED || lt_in[i] == YEL || lt_in[i] == GRN);
      t3[i]  = (prev_q[i] == GRN) && (lt_in[i] == RED);
      t4[i]  = (prev_q[i] == YEL) && (lt_in[i] == RED) && (ycnt_q[i] < YW'(MIN_YELLOW));
      if ((la_in[i] || ra_in[i]) && lt_in[i] == RED) c5 = 1'b1;
    end
    c1      = (lt_in[0] != RED || lt_in[1] != RED) && (lt_in[2] != RED || lt_in[3] != RED);
    c2      = |bad;
    viol    = c1 || c2 || c5;
    hit     = (state_q == ST_MONITOR) && viol && (deb_q == DW'(DEBOUNCE - 1));
    // mon_q is low on the first MONITOR cycle, so history from STARTUP is never judged
    temp_en = (state_q == ST_MONITOR) && mon_q;
    if (hit && c1)              new_code = 3'd1;
    else if (hit && c2)         new_code = 3'd2;
    else if (temp_en && |t3)    new_code = 3'd3;
    else if (temp_en && |t4)    new_code = 3'd4;
    else if (hit && c5)         new_code = 3'd5;
    else                        new_code = 3'd0;
  end

  always_comb begin
    state_d = state_q;
    stc_d   = stc_q;
    deb_d   = '0;
    fcnt_d  = fcnt_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    lt_d    = {4{RED}};
    la_d    = '0;
    ra_d    = '0;
    prev_d  = lt_in;
    for (int i = 0; i < 4; i++) begin
      if (lt_in[i] != YEL)                     ycnt_d[i] = '0;
      else if (ycnt_q[i] == YW'(MIN_YELLOW))   ycnt_d[i] = ycnt_q[i];
      else                                     ycnt_d[i] = ycnt_q[i] + YW'(1);
    end
    case (state_q)
      ST_STARTUP: begin
        if (stc_q == SW'(STARTUP_CYCLES - 1)) state_d = ST_MONITOR;
        else                                  stc_d   = stc_q + SW'(1);
      end
      ST_MONITOR: begin
        if (new_code != 3'd0) begin
          state_d = ST_FAULT;
          code_d  = new_code;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          fcnt_d  = FW'(1);
        end else if (viol) begin
          deb_d = deb_q + DW'(1);
        end else begin
          lt_d = lt_in;
          la_d = la_in;
          ra_d = ra_in;
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          state_d = ST_STARTUP;
          stc_d   = '0;
          code_d  = 3'd0;
          ycnt_d  = '0;
        end else begin
          lt_d   = (fcnt_q < FW'(FLASH_HALF)) ? {4{RED}} : '0;
          fcnt_d = (fcnt_q == FW'(2 * FLASH_HALF - 1)) ? '0 : fcnt_q + FW'(1);
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STARTUP;
      stc_q   <= '0;
      deb_q   <= '0;
      fcnt_q  <= '0;
      code_q  <= 3'd0;
      cnt_q   <= 8'd0;
      lt_q    <= {4{RED}};
      la_q    <= '0;
      ra_q    <= '0;
      prev_q  <= {4{RED}};
      ycnt_q  <= '0;
      mon_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stc_q   <= stc_d;
      deb_q   <= deb_d;
      fcnt_q  <= fcnt_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      la_q    <= la_d;
      ra_q    <= ra_d;
      prev_q  <= prev_d;
      ycnt_q  <= ycnt_d;
      mon_q   <= (state_q == ST_MONITOR);
    end
  end

  assign safe_north_light   = lt_q[0];
  assign safe_south_light   = lt_q[1];
  assign safe_east_light    = lt_q[2];
  assign safe_west_light    = lt_q[3];
  assign safe_n_left_arrow  = la_q[0];
  assign safe_s_left_arrow  = la_q[1];
  assign safe_e_left_arrow  = la_q[2];
  assign safe_w_left_arrow  = la_q[3];
  assign safe_n_right_arrow = ra_q[0];
  assign safe_s_right_arrow = ra_q[1];
  assign safe_e_right_arrow = ra_q[2];
  assign safe_w_right_arrow = ra_q[3];
  assign fault              = (state_q == ST_FAULT);
  assign fault_code         = code_q;
  assign fault_count        = cnt_q;
endmodule
